ex_operand_muldiv: RTL and testbench

Execute-stage operand block directly downstream of the forwarding unit. It consumes `forwardA`/`forwardB` and selects the final rs1/rs2 operands for the ALU, branch comparator and store-data path. It also runs an iterative 32-cycle RV32M multiply/divide engine on those operands. While the engine is working it raises a stall request that freezes IF/ID/EX.

---
 rtl/rv32i_types.sv | 26 ++
 rtl/ex_operand_muldiv_if.sv | 23 ++
 rtl/ex_operand_muldiv_muldiv_iter.sv | 141 ++++++++++++++
 rtl/ex_operand_muldiv.sv | 47 ++++
 tb/tb_ex_operand_muldiv.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_types.sv
// Shared RV32 execute-stage types: M-extension funct3 encodings, the
// forwarding-select constants used with the forwarding unit, and mul/div FSM states.
package rv32i_types;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_funct3_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  localparam logic [1:0] fwd_idex = 2'b00;
  localparam logic [1:0] fwd_mem  = 2'b10;
  localparam logic [1:0] fwd_wb   = 2'b01;

endpackage

// File: rtl/ex_operand_muldiv_if.sv
// Mul/div issue and completion signals between the EX pipeline control
// (master) and the operand/mul-div block (slave).
interface ex_operand_muldiv_if #(
  parameter int XLEN = 32
);
  logic            ex_valid;
  logic            ex_is_muldiv;
  logic [2:0]      ex_funct3;
  logic            flush;
  logic [XLEN-1:0] md_result;
  logic            md_done;
  logic            md_stall;

  modport master (
    output ex_valid, ex_is_muldiv, ex_funct3, flush,
    input  md_result, md_done, md_stall
  );

  modport slave (
    input  ex_valid, ex_is_muldiv, ex_funct3, flush,
    output md_result, md_done, md_stall
  );
endinterface

// File: rtl/ex_operand_muldiv_muldiv_iter.sv
// Iterative RV32M engine: one shift-add or restoring shift-subtract step per
// CALC cycle on operand magnitudes, with sign fixup on the final step.
module muldiv_iter
  import rv32i_types::*;
#(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  ex_operand_muldiv_if.slave md
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t         state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  muldiv_funct3_t    f3_q, f3_d, f3_in;
  logic              neg_q, neg_d, rneg_q, rneg_d;
  logic [XLEN-1:0]   b_q, b_d, res_q, res_d;
  logic [2*XLEN-1:0] acc_q, acc_d, acc_step, prod_fix;
  logic [XLEN:0]     sum, rem_sh;
  logic [XLEN-1:0]   quo, rem, quo_fix, rem_fix, fix_res, special_res, mag_a, mag_b;
  logic signed [XLEN-1:0] a_s, b_s;
  logic              a_sgn, b_sgn, sa, sb, start, div0, ovf, special;

  // Issue decode: signedness, magnitudes and the cases that skip iteration
  always_comb begin
    f3_in   = muldiv_funct3_t'(md.ex_funct3);
    a_s     = signed'(op_a);
    b_s     = signed'(op_b);
    a_sgn   = f3_in inside {MULH, MULHSU, DIV, REM};
    b_sgn   = f3_in inside {MULH, DIV, REM};
    sa      = a_sgn && (a_s < 0);
    sb      = b_sgn && (b_s < 0);
    mag_a   = sa ? -op_a : op_a;
    mag_b   = sb ? -op_b : op_b;
    start   = md.ex_valid & md.ex_is_muldiv & ~md.flush;
    div0    = md.ex_funct3[2] && (op_b == '0);
    ovf     = (f3_in == DIV || f3_in == REM) && (op_a == INT_MIN) && (b_s == -1);
    special = div0 || ovf;
    special_res = div0 ? (md.ex_funct3[1] ? op_a : '1)
                       : ((f3_in == DIV) ? INT_MIN : '0);
  end

  // One iteration; acc holds {partial product, multiplier} or {remainder, quotient}
  always_comb begin
    sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    rem_sh = acc_q[2*XLEN-1:XLEN-1];
    if (f3_q inside {DIV, DIVU, REM, REMU}) begin
      if (rem_sh >= {1'b0, b_q}) acc_step = {rem_sh[XLEN-1:0] - b_q, acc_q[XLEN-2:0], 1'b1};
      else                       acc_step = {acc_q[2*XLEN-2:0], 1'b0};
    end else begin
      acc_step = {sum, acc_q[XLEN-1:1]};
    end
    prod_fix = neg_q ? -acc_step : acc_step;
    quo      = acc_step[XLEN-1:0];
    rem      = acc_step[2*XLEN-1:XLEN];
    quo_fix  = neg_q ? -quo : quo;
    rem_fix  = rneg_q ? -rem : rem;
    case (f3_q)
      MUL:                 fix_res = prod_fix[XLEN-1:0];
      MULH, MULHSU, MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      DIV, DIVU:           fix_res = quo_fix;
      default:             fix_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    f3_d        = f3_q;
    neg_d       = neg_q;
    rneg_d      = rneg_q;
    b_d         = b_q;
    acc_d       = acc_q;
    res_d       = res_q;
    md.md_done  = 1'b0;
    md.md_stall = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          md.md_stall = 1'b1;
          if (special) begin
            state_d = MD_DONE;
            res_d   = special_res;
          end else begin
            state_d = MD_CALC;
            cnt_d   = 6'(MD_CYCLES - 1);
            f3_d    = f3_in;
            neg_d   = sa ^ sb;
            rneg_d  = sa;
            b_d     = mag_b;
            acc_d   = {{XLEN{1'b0}}, mag_a};
          end
        end
      end
      MD_CALC: begin
        if (md.flush) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
        end else begin
          md.md_stall = 1'b1;
          acc_d       = acc_step;
          if (cnt_q == '0) begin
            state_d = MD_DONE;
            res_d   = fix_res;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
      end
      default: begin
        md.md_done = ~md.flush;
        state_d    = MD_IDLE;
      end
    endcase
  end

  assign md.md_result = res_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
    f3_q   <= f3_d;
    neg_q  <= neg_d;
    rneg_q <= rneg_d;
    b_q    <= b_d;
    acc_q  <= acc_d;
  end

endmodule

// File: rtl/ex_operand_muldiv.sv
// Execute-stage operand select (forwarding muxes) feeding the ALU, branch
// comparator and store path, plus the iterative mul/div engine.
module ex_operand_muldiv
  import rv32i_types::*;
#(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      forwardA,
  input  logic [1:0]      forwardB,
  input  logic [XLEN-1:0] id_ex_rs1_data,
  input  logic [XLEN-1:0] id_ex_rs2_data,
  input  logic [XLEN-1:0] ex_mem_fwd_data,
  input  logic [XLEN-1:0] mem_wb_fwd_data,
  output logic [XLEN-1:0] rs1_fwd,
  output logic [XLEN-1:0] rs2_fwd,
  ex_operand_muldiv_if.slave md
);

  // Select code 11 is unused by the forwarding unit and falls back to ID/EX
  always_comb begin
    case (forwardA)
      fwd_mem: rs1_fwd = ex_mem_fwd_data;
      fwd_wb:  rs1_fwd = mem_wb_fwd_data;
      default: rs1_fwd = id_ex_rs1_data;
    endcase
    case (forwardB)
      fwd_mem: rs2_fwd = ex_mem_fwd_data;
      fwd_wb:  rs2_fwd = mem_wb_fwd_data;
      default: rs2_fwd = id_ex_rs2_data;
    endcase
  end

  muldiv_iter #(
    .XLEN      (XLEN),
    .MD_CYCLES (MD_CYCLES)
  ) u_muldiv_iter (
    .clk  (clk),
    .rst  (rst),
    .op_a (rs1_fwd),
    .op_b (rs2_fwd),
    .md   (md)
  );

endmodule

// File: tb/tb_ex_operand_muldiv.sv
// Directed bench for ex_operand_muldiv: an RV32M arithmetic model plus a
// cycle timeline model checked every cycle, pinned by hand-computed literals.
module tb_ex_operand_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  forwardA, forwardB;
  logic [31:0] id1, id2, exm, mwb, rs1_fwd, rs2_fwd;

  ex_operand_muldiv_if #(.XLEN(32)) md_if ();

  ex_operand_muldiv #(.XLEN(32), .MD_CYCLES(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .forwardA        (forwardA),
    .forwardB        (forwardB),
    .id_ex_rs1_data  (id1),
    .id_ex_rs2_data  (id2),
    .ex_mem_fwd_data (exm),
    .mem_wb_fwd_data (mwb),
    .rs1_fwd         (rs1_fwd),
    .rs2_fwd         (rs2_fwd),
    .md              (md_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_chk  = 0;
  int          n_pass = 0;
  bit          chk_en = 0, busy = 0, skip_stall = 0;
  int          issue_cyc = 0, done_cyc = 0;
  logic [31:0] exp_res = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %08h, expected %08h", name, cyc, act, exp);
  endtask

  function automatic logic [31:0] fwd_ref(input logic [1:0] s, input logic [31:0] r,
                                          input logic [31:0] e, input logic [31:0] w);
    if (s == 2'b10) return e;
    if (s == 2'b01) return w;
    return r;
  endfunction

  // RV32M semantics straight from the ISA definition
  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic signed [31:0] sa, sb, sq;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin up = {32'h0, a} * {32'h0, b}; return up[31:0]; end
      3'd1: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[63:32]; end
      3'd2: begin up = {{32{a[31]}}, a} * {32'h0, b}; return up[63:32]; end
      3'd3: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        sq = sa / sb; return sq;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        sq = sa % sb; return sq;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Per-cycle comparison against the timeline and arithmetic models
  always @(negedge clk) begin
    logic es, ed;
    if (chk_en) begin
      es = busy && (cyc >= issue_cyc) && (cyc < done_cyc);
      ed = busy && (cyc == done_cyc);
      if (!skip_stall) check("md_stall", {31'b0, md_if.md_stall}, {31'b0, es});
      check("md_done", {31'b0, md_if.md_done}, {31'b0, ed});
      if (ed) check("md_result", md_if.md_result, exp_res);
      check("rs1_fwd", rs1_fwd, fwd_ref(forwardA, id1, exm, mwb));
      check("rs2_fwd", rs2_fwd, fwd_ref(forwardB, id2, exm, mwb));
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [1:0] fa, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] lit,
                       input int chg_at, input int flush_at, input int rst_at);
    bit special;
    int n;
    @(posedge clk); #1;
    md_if.ex_valid     = 1'b1;
    md_if.ex_is_muldiv = 1'b1;
    md_if.ex_funct3    = f3;
    md_if.flush        = 1'b0;
    forwardA = fa;
    forwardB = 2'b00;
    if (fa == 2'b10) begin exm = a; id1 = 32'h0BAD_0BAD; end
    else id1 = a;
    id2 = b;
    special = (f3[2] && b == 0) ||
              ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    exp_res   = ref_md(f3, a, b);
    issue_cyc = cyc;
    done_cyc  = cyc + (special ? 1 : 33);
    busy      = 1;
    n = done_cyc - issue_cyc;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      if (k == chg_at) exm = 32'hDEAD_BEEF;
      if (k == flush_at || k == rst_at) begin
        busy = 0;
        if (k == flush_at) md_if.flush = 1'b1;
        else begin rst = 1'b1; md_if.ex_valid = 1'b0; skip_stall = 1; end
        @(posedge clk); #1;
        md_if.flush = 1'b0;
        md_if.ex_valid = 1'b0;
        if (k == rst_at) check("md_result_after_rst", md_if.md_result, 32'h0);
        rst = 1'b0;
        skip_stall = 0;
        return;
      end
    end
    check("md_result_literal", md_if.md_result, lit);
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    md_if.ex_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0]  sel [4];
    logic [31:0] e1 [4];
    logic [31:0] e2 [4];
    sel = '{2'b00, 2'b10, 2'b01, 2'b11};
    e1  = '{32'h11, 32'h22, 32'h33, 32'h11};
    e2  = '{32'h44, 32'h22, 32'h33, 32'h44};

    rst = 1'b1;
    forwardA = 2'b00; forwardB = 2'b00;
    id1 = '0; id2 = '0; exm = '0; mwb = '0;
    md_if.ex_valid = 1'b0; md_if.ex_is_muldiv = 1'b0;
    md_if.ex_funct3 = 3'd0; md_if.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_md_stall", {31'b0, md_if.md_stall}, 32'h0);
    check("reset_md_done", {31'b0, md_if.md_done}, 32'h0);
    check("reset_md_result", md_if.md_result, 32'h0);
    rst = 1'b0;
    chk_en = 1;

    id1 = 32'h11; id2 = 32'h44; exm = 32'h22; mwb = 32'h33;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      forwardA = sel[i]; forwardB = sel[i];
      #1;
      check("fwd_rs1_literal", rs1_fwd, e1[i]);
      check("fwd_rs2_literal", rs2_fwd, e2[i]);
    end

    // MULH then MUL back to back, second issued in the cycle after DONE
    issue(3'd1, 2'b00, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 0, 0, 0);
    issue(3'd0, 2'b00, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFA, 0, 0, 0);
    issue(3'd2, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    idle(2);
    issue(3'd4, 2'b00, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 0, 0, 0);
    issue(3'd6, 2'b00, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 0, 0, 0);
    issue(3'd5, 2'b00, 32'h7, 32'h0, 32'hFFFF_FFFF, 0, 0, 0);
    issue(3'd7, 2'b00, 32'h7, 32'h0, 32'h7, 0, 0, 0);
    issue(3'd4, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 0);
    issue(3'd6, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, 0, 0);
    issue(3'd5, 2'b00, 32'hFFFF_FFFF, 32'h8000_0001, 32'h1, 0, 0, 0);
    issue(3'd7, 2'b00, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 0, 0, 0);
    idle(2);

    // Forwarded operand changes after the engine has latched it
    issue(3'd0, 2'b10, 32'h5, 32'h6, 32'd30, 3, 0, 0);
    idle(1);

    // Ordinary ALU instruction in EX leaves the engine alone
    @(posedge clk); #1;
    busy = 0;
    md_if.ex_valid = 1'b1; md_if.ex_is_muldiv = 1'b0; md_if.ex_funct3 = 3'd4;
    id2 = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    md_if.ex_valid = 1'b0;
    idle(1);

    issue(3'd3, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 0, 10, 0);
    idle(2);
    issue(3'd3, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 0, 0, 20);
    idle(2);
    issue(3'd3, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0, 0);
    idle(3);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
